// File: rtl/sequential_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sequential_multiplier_pkg
// Description : Shared definitions for the sequential signed multiplier:
//               the control state encoding and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sequential_multiplier_pkg;

    localparam int C_DEFAULT_WORD_LENGTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The bit counter must be able to represent 0..WORD_LENGTH.
    function automatic int count_width(input int word_length);
        return $clog2(word_length + 1);
    endfunction

endpackage : sequential_multiplier_pkg
`default_nettype wire

// File: rtl/sequential_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : sequential_multiplier_if
// Description : Request/result bundle of the sequential multiplier.
//               master: drives start, Multiplier, Multiplicand; sees result.
//               slave : the multiplier; drives ready and Product.
// Revision    : 1.0 - initial release
// ============================================================================
interface sequential_multiplier_if #(
    parameter int WORD_LENGTH = 8
);
    logic                         start;
    logic [WORD_LENGTH-1:0]       Multiplier;
    logic [WORD_LENGTH-1:0]       Multiplicand;
    logic                         ready;
    logic [2*WORD_LENGTH-1:0]     Product;

    modport master (
        output start,
        output Multiplier,
        output Multiplicand,
        input  ready,
        input  Product
    );

    modport slave (
        input  start,
        input  Multiplier,
        input  Multiplicand,
        output ready,
        output Product
    );
endinterface : sequential_multiplier_if
`default_nettype wire

// File: rtl/seq_mult_datapath.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_datapath
// Description : Sign/magnitude capture, shift-and-add accumulator and final
//               conditional negation for the sequential multiplier.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               i_capture        - latch operand magnitudes and result sign
//               i_step           - process one multiplier bit
//               i_load           - publish the signed result on o_product
//               i_multiplier     - signed operand
//               i_multiplicand   - signed operand
//               o_product        - signed 2*WORD_LENGTH result
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_datapath #(
    parameter int WORD_LENGTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     i_capture,
    input  wire logic                     i_step,
    input  wire logic                     i_load,
    input  wire logic [WORD_LENGTH-1:0]   i_multiplier,
    input  wire logic [WORD_LENGTH-1:0]   i_multiplicand,
    output logic      [2*WORD_LENGTH-1:0] o_product
);

    logic [WORD_LENGTH-1:0]   w_mplier_mag;
    logic [WORD_LENGTH-1:0]   w_mcand_mag;
    logic [WORD_LENGTH-1:0]   r_mplier;
    logic [2*WORD_LENGTH-1:0] r_mcand_sh;
    logic [2*WORD_LENGTH-1:0] r_acc;
    logic                     r_sign;

    // Magnitude of the most negative value wraps to 2^(WORD_LENGTH-1),
    // which is exactly right when read as unsigned.
    assign w_mplier_mag = i_multiplier[WORD_LENGTH-1]
                        ? (~i_multiplier + WORD_LENGTH'(1)) : i_multiplier;
    assign w_mcand_mag  = i_multiplicand[WORD_LENGTH-1]
                        ? (~i_multiplicand + WORD_LENGTH'(1)) : i_multiplicand;

    // Multiplier shifts right so bit 0 is always the current bit; the
    // multiplicand shifts left so it always equals mag << counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mplier   <= '0;
            r_mcand_sh <= '0;
            r_acc      <= '0;
            r_sign     <= 1'b0;
            o_product  <= '0;
        end else begin
            if (i_capture) begin
                r_mplier   <= w_mplier_mag;
                r_mcand_sh <= {{WORD_LENGTH{1'b0}}, w_mcand_mag};
                r_acc      <= '0;
                r_sign     <= i_multiplier[WORD_LENGTH-1] ^ i_multiplicand[WORD_LENGTH-1];
            end else if (i_step) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand_sh;
                end
                r_mplier   <= r_mplier >> 1;
                r_mcand_sh <= r_mcand_sh << 1;
            end
            // Negating a zero accumulator yields zero, so no negative zero.
            if (i_load) begin
                o_product <= r_sign ? (~r_acc + (2*WORD_LENGTH)'(1)) : r_acc;
            end
        end
    end

endmodule : seq_mult_datapath
`default_nettype wire

// File: rtl/sequential_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : sequential_multiplier
// Description : Iterative signed shift-and-add multiplier, one partial
//               product per clock. Control FSM and bit counter live here.
// Ports       : clk    - system clock
//               reset  - synchronous active-high reset
//               bus    - slave side of sequential_multiplier_if
//                        (start, Multiplier, Multiplicand -> ready, Product)
// Revision    : 1.0 - initial release
// ============================================================================
module sequential_multiplier
    import sequential_multiplier_pkg::*;
#(
    parameter int WORD_LENGTH = C_DEFAULT_WORD_LENGTH
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    sequential_multiplier_if.slave       bus
);

    localparam int C_CNT_W = count_width(WORD_LENGTH);

    state_t               r_state;
    state_t               w_state_next;
    logic [C_CNT_W-1:0]   r_count;
    logic                 r_ready;
    logic                 w_accept;
    logic                 w_step;
    logic                 w_load;
    logic                 w_last_bit;

    assign w_last_bit = (r_count == C_CNT_W'(WORD_LENGTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_count <= '0;
            end else if (w_step) begin
                r_count <= r_count + C_CNT_W'(1);
            end
            // ready survives the return to IDLE and only drops on a new accept.
            if (w_accept) begin
                r_ready <= 1'b0;
            end else if (w_load) begin
                r_ready <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_step = 1'b1;
                if (w_last_bit) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Reloading while parked here rewrites the same value.
                w_load = 1'b1;
                if (!bus.start) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    logic [2*WORD_LENGTH-1:0] w_product;

    seq_mult_datapath #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_datapath (
        .clk            (clk),
        .reset          (reset),
        .i_capture      (w_accept),
        .i_step         (w_step),
        .i_load         (w_load),
        .i_multiplier   (bus.Multiplier),
        .i_multiplicand (bus.Multiplicand),
        .o_product      (w_product)
    );

    assign bus.ready   = r_ready;
    assign bus.Product = w_product;

endmodule : sequential_multiplier
`default_nettype wire

// File: tb/tb_sequential_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_sequential_multiplier
// Description : Directed self-checking bench for sequential_multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sequential_multiplier;

    localparam int C_W = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sequential_multiplier_if #(.WORD_LENGTH(C_W)) bus ();

    sequential_multiplier #(
        .WORD_LENGTH (C_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        checks++;
        assert (bus.ready === exp) else begin
            failures++;
            $error("FAIL %s ready observed=%b expected=%b", tag, bus.ready, exp);
        end
    endtask

    task automatic chk_prod(input string tag, input logic [2*C_W-1:0] exp);
        checks++;
        assert (bus.Product === exp) else begin
            failures++;
            $error("FAIL %s Product observed=0x%h expected=0x%h", tag, bus.Product, exp);
        end
    endtask

    // One full operation with start pulsed for a single cycle; optionally
    // scrambles the operands while busy.
    task automatic run_op(input string tag, input logic [C_W-1:0] a,
                          input logic [C_W-1:0] b, input logic [2*C_W-1:0] exp,
                          input bit scramble);
        bus.Multiplier   = a;
        bus.Multiplicand = b;
        bus.start        = 1'b1;
        edges(1);                       // accepting edge 0
        chk_ready({tag, "_accept"}, 1'b0);
        bus.start = 1'b0;
        if (scramble) begin
            bus.Multiplier   = 8'h7F;
            bus.Multiplicand = 8'h81;
        end
        edges(C_W);                     // edge WORD_LENGTH: still not ready
        chk_ready({tag, "_early"}, 1'b0);
        edges(1);                       // edge WORD_LENGTH+1
        chk_ready({tag, "_done"}, 1'b1);
        chk_prod(tag, exp);
        edges(1);                       // back to IDLE, result held
        chk_ready({tag, "_hold"}, 1'b1);
        chk_prod({tag, "_hold"}, exp);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.start        = 1'b1;        // start during reset must be ignored
        bus.Multiplier   = 8'd5;
        bus.Multiplicand = 8'd5;
        edges(2);
        chk_ready("reset", 1'b0);
        chk_prod("reset", 16'h0000);
        bus.start = 1'b0;
        reset     = 1'b0;
        edges(C_W + 2);
        chk_ready("reset_no_start", 1'b0);
        chk_prod("reset_no_start", 16'h0000);

        // 6 x 3 with start held for 4 clocks
        bus.Multiplier   = 8'd6;
        bus.Multiplicand = 8'd3;
        bus.start        = 1'b1;
        edges(4);                       // edges 0..3
        chk_ready("pp_busy", 1'b0);
        bus.start = 1'b0;
        edges(5);                       // edge 8
        chk_ready("pp_early", 1'b0);
        chk_prod("pp_early", 16'h0000);
        edges(1);                       // edge 9
        chk_ready("pp_done", 1'b1);
        chk_prod("pp", 16'h0012);
        edges(2);
        chk_ready("pp_idle_hold", 1'b1);
        chk_prod("pp_idle_hold", 16'h0012);

        run_op("mixed", 8'd2, 8'd251, 16'hFFF6, 1'b0);
        run_op("neg_neg_min", 8'h80, 8'h80, 16'h4000, 1'b0);
        run_op("min_max", 8'h80, 8'h7F, 16'hC080, 1'b0);
        run_op("zero", 8'h00, 8'hFF, 16'h0000, 1'b0);
        run_op("m1_m1", 8'hFF, 8'hFF, 16'h0001, 1'b0);
        run_op("captured", 8'd9, 8'd10, 16'h005A, 1'b1);

        // Start held through DONE must not retrigger: -3 x 5
        bus.Multiplier   = 8'hFD;
        bus.Multiplicand = 8'd5;
        bus.start        = 1'b1;
        edges(C_W + 2);
        chk_ready("hold_done", 1'b1);
        chk_prod("hold", 16'hFFF1);
        edges(4);
        chk_ready("hold_no_retrigger", 1'b1);
        chk_prod("hold_no_retrigger", 16'hFFF1);
        bus.start = 1'b0;
        edges(2);

        // Reset at BUSY cycle 3 aborts; previous result is cleared
        bus.Multiplier   = 8'd5;
        bus.Multiplicand = 8'd5;
        bus.start        = 1'b1;
        edges(1);
        bus.start = 1'b0;
        edges(3);
        reset = 1'b1;
        edges(1);
        chk_ready("mid_reset", 1'b0);
        chk_prod("mid_reset", 16'h0000);
        reset = 1'b0;
        edges(C_W + 2);
        chk_ready("mid_reset_idle", 1'b0);
        chk_prod("mid_reset_idle", 16'h0000);

        run_op("post_reset", 8'd7, 8'hF9, 16'hFFCF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sequential_multiplier
`default_nettype wire
